// File: rtl/s2p_pkg.sv
// Shared types and default sizes for the serial-to-parallel deserializer.
// Contents: FSM state enum, default word width and output FIFO depth.
// Imported by s2p_fifo and serial_to_parallel.
package s2p_pkg;

   typedef enum logic [0:0] {
      S2P_IDLE  = 1'b0,
      S2P_SHIFT = 1'b1
   } s2p_state_t;

   localparam int S2P_WIDTH = 4;
   localparam int S2P_DEPTH = 2;

endpackage

// File: rtl/s2p_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding reassembled words.
// Ports: push_i/data_i write side, pop_i/data_o read side (data_o is 0 when empty),
//        full_o/empty_o status, count_o occupancy. A push while full is accepted only with a same-cycle pop.
module s2p_fifo
   import s2p_pkg::*;
#(
   parameter int WIDTH = S2P_WIDTH,
   parameter int DEPTH = S2P_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q,  count_d;
   logic             pop_eff;
   logic             push_eff;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // A pop frees the slot the push needs, so full+pop still takes the word.
   assign pop_eff  = pop_i && !empty_o;
   assign push_eff = push_i && (!full_o || pop_eff);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: reassembles LSB-first serial bits into WIDTH-bit words, buffered in a FIFO.
// Ports: serial_i/valid_i bit stream, clear_i clears overflow; parallel_o/_valid_o/_ready_i word output,
//        level_o FIFO occupancy, overflow_o sticky drop flag, frame_err_o one-cycle partial-word discard pulse.
module serial_to_parallel
   import s2p_pkg::*;
#(
   parameter int WIDTH = S2P_WIDTH,
   parameter int DEPTH = S2P_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       serial_i,
   input  logic                       valid_i,
   input  logic                       clear_i,
   output logic [WIDTH-1:0]           parallel_o,
   output logic                       parallel_valid_o,
   input  logic                       parallel_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   output logic                       frame_err_o
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH-1);

   s2p_state_t       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             frame_err_q, frame_err_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] word;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   // New bit enters at the top; after WIDTH shifts the first bit is at bit 0.
   assign word = {serial_i, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         S2P_IDLE: begin
            if (valid_i) begin
               shreg_d   = word;
               bit_cnt_d = CNT_W'(1);
               state_d   = S2P_SHIFT;
            end
         end
         S2P_SHIFT: begin
            if (valid_i) begin
               shreg_d = word;
               if (bit_cnt_q == LAST) begin
                  push      = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = S2P_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               // Gap inside a word: drop the partial word and flag it.
               bit_cnt_d   = '0;
               state_d     = S2P_IDLE;
               frame_err_d = 1'b1;
            end
         end
         default: begin
            bit_cnt_d = '0;
            state_d   = S2P_IDLE;
         end
      endcase
   end

   assign pop = !empty && parallel_ready_i;

   // Set wins over clear so a drop in the clearing cycle is never lost.
   assign overflow_d = (push && full && !pop) || (overflow_q && !clear_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S2P_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   s2p_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (word),
      .pop_i   (pop),
      .data_o  (parallel_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (level_o)
   );

   assign parallel_valid_o = !empty;
   assign overflow_o       = overflow_q;
   assign frame_err_o      = frame_err_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_i;
   logic       valid_i;
   logic       clear_i;
   logic [3:0] parallel_o;
   logic       parallel_valid_o;
   logic       parallel_ready_i;
   logic [1:0] level_o;
   logic       overflow_o;
   logic       frame_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   serial_to_parallel #(.WIDTH(4), .DEPTH(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .serial_i         (serial_i),
      .valid_i          (valid_i),
      .clear_i          (clear_i),
      .parallel_o       (parallel_o),
      .parallel_valid_o (parallel_valid_o),
      .parallel_ready_i (parallel_ready_i),
      .level_o          (level_o),
      .overflow_o       (overflow_o),
      .frame_err_o      (frame_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output state after the most recent edge.
   task automatic chk_out(input string tag, input logic [3:0] d, input logic v,
                          input logic [1:0] lvl, input logic ovf, input logic ferr);
      chk({tag, ".data"},  32'(parallel_o),       32'(d));
      chk({tag, ".valid"}, 32'(parallel_valid_o), 32'(v));
      chk({tag, ".level"}, 32'(level_o),          32'(lvl));
      chk({tag, ".ovf"},   32'(overflow_o),       32'(ovf));
      chk({tag, ".ferr"},  32'(frame_err_o),      32'(ferr));
   endtask

   task automatic send_bit(input logic b);
      serial_i = b;
      valid_i  = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      valid_i  = 1'b0;
      serial_i = 1'b0;
      @(posedge clk); #1;
   endtask

   // Sends bits 0..2 of a nibble LSB first; the 4th bit is sent by the caller.
   task automatic send3(input logic [3:0] w);
      for (int i = 0; i < 3; i++) send_bit(w[i]);
   endtask

   initial begin
      reset = 1'b1; serial_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0; parallel_ready_i = 1'b0;
      #2;
      chk_out("reset", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Bits 0,1,0,1 -> 4'hA, visible right after the 4th sampling edge.
      send3(4'hA);
      chk_out("a_partial", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      send_bit(1'b1);
      chk_out("a_word", 4'hA, 1'b1, 2'd1, 1'b0, 1'b0);
      parallel_ready_i = 1'b1;
      idle();
      chk_out("a_popped", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

      // 3 then C with a single reload gap: no frame error.
      send3(4'h3); send_bit(1'b0);
      chk_out("w3", 4'h3, 1'b1, 2'd1, 1'b0, 1'b0);
      idle();
      chk_out("gap", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      send3(4'hC); send_bit(1'b1);
      chk_out("wC", 4'hC, 1'b1, 2'd1, 1'b0, 1'b0);
      idle();
      chk_out("wC_pop", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Two bits then a gap: one-cycle frame error, nothing pushed.
      send_bit(1'b1); send_bit(1'b1);
      idle();
      chk_out("ferr_pulse", 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
      idle();
      chk_out("ferr_clear", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      send3(4'hF); send_bit(1'b1);
      chk_out("wF", 4'hF, 1'b1, 2'd1, 1'b0, 1'b0);
      idle();
      chk_out("wF_pop", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Ready low: 1 and 2 fill the FIFO, 3 is dropped.
      parallel_ready_i = 1'b0;
      send3(4'h1); send_bit(1'b0); idle();
      send3(4'h2); send_bit(1'b0);
      chk_out("full", 4'h1, 1'b1, 2'd2, 1'b0, 1'b0);
      idle();
      chk_out("hold", 4'h1, 1'b1, 2'd2, 1'b0, 1'b0);
      send3(4'h3); send_bit(1'b0);
      chk_out("drop", 4'h1, 1'b1, 2'd2, 1'b1, 1'b0);
      parallel_ready_i = 1'b1;
      idle();
      chk_out("pop1", 4'h2, 1'b1, 2'd1, 1'b1, 1'b0);
      idle();
      chk_out("pop2", 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
      clear_i = 1'b1;
      idle();
      clear_i = 1'b0;
      chk_out("clear", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Full FIFO with ready on the completing edge: push and pop together.
      parallel_ready_i = 1'b0;
      send3(4'h6); send_bit(1'b0); idle();
      send3(4'h9); send_bit(1'b1); idle();
      chk_out("full2", 4'h6, 1'b1, 2'd2, 1'b0, 1'b0);
      send3(4'h5);
      parallel_ready_i = 1'b1;
      send_bit(1'b0);
      chk_out("push_pop", 4'h9, 1'b1, 2'd2, 1'b0, 1'b0);
      idle();
      chk_out("order5", 4'h5, 1'b1, 2'd1, 1'b0, 1'b0);
      idle();
      chk_out("drain", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Overflow, buffered words and a partial word, then async reset mid-cycle.
      parallel_ready_i = 1'b0;
      send3(4'h7); send_bit(1'b0); idle();
      send3(4'h7); send_bit(1'b0); idle();
      send3(4'h7); send_bit(1'b0);
      chk_out("pre_rst", 4'h7, 1'b1, 2'd2, 1'b1, 1'b0);
      send_bit(1'b1); send_bit(1'b1);
      reset = 1'b1;
      #2;
      chk_out("async_rst", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
      valid_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      send3(4'h5); send_bit(1'b0);
      chk_out("after_rst", 4'h5, 1'b1, 2'd1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
